// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a bank of 7-segment digits that share one decoder.
// Shadow digit store is written over valid/ready; the active store is swapped in at frame end on commit.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_idx,
    input  logic [2:0]            wr_data,
    input  logic                  wr_on,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    output logic                  commit_done,
    output logic [2:0]            dec_in,
    input  logic [6:0]            dec_out,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out
);

    localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]     DIGITS    = 4'(NUM_DIGITS);

    typedef enum logic {
        C_IDLE,
        C_PENDING
    } commit_state_t;

    typedef enum logic {
        BLANK,
        SHOW
    } phase_t;

    commit_state_t state, next_state;
    phase_t        phase;

    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic              frame_end;
    logic              copy;
    logic              wr_fire;
    logic [7:0][2:0]   shadow_val;
    logic [7:0]        shadow_on;
    logic [7:0][2:0]   active_val;
    logic [7:0]        active_on;

    assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign wr_fire   = wr_valid && wr_ready;
    assign dec_in    = active_val[idx];
    assign phase     = (cnt < BLANK_END) ? BLANK : SHOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= C_IDLE;
            commit_done <= 1'b0;
        end else begin
            state       <= next_state;
            commit_done <= copy;
        end
    end

    // A commit only waits for a frame end seen after its accept cycle, so the
    // accept-cycle frame end is skipped naturally by the registered state.
    always_comb begin
        next_state   = state;
        copy         = 1'b0;
        wr_ready     = (state == C_IDLE);
        commit_ready = (state == C_IDLE);
        case (state)
            C_IDLE: begin
                if (commit_valid) next_state = C_PENDING;
            end
            C_PENDING: begin
                if (frame_end) begin
                    copy       = 1'b1;
                    next_state = C_IDLE;
                end
            end
            default: next_state = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_on  <= '0;
            active_val <= '0;
            active_on  <= '0;
        end else begin
            if (wr_fire && ({1'b0, wr_idx} < DIGITS)) begin
                shadow_val[wr_idx] <= wr_data;
                shadow_on[wr_idx]  <= wr_on;
            end
            if (copy) begin
                active_val <= shadow_val;
                active_on  <= shadow_on;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out <= 7'h7F;
            an_out  <= '1;
        end else if (phase == SHOW && active_on[idx]) begin
            seg_out <= dec_out;
            an_out  <= ~(NUM_DIGITS'(1) << idx);
        end else begin
            seg_out <= 7'h7F;
            an_out  <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl, checked against a cycle-time model of
// the scan sequence (slot and prescaler derived from elapsed cycles since reset).
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DV    = 10;
    localparam int BC    = 2;
    localparam int FRAME = ND * DV;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_idx;
    logic [2:0]    wr_data;
    logic          wr_on;
    logic          commit_valid;
    logic          commit_ready;
    logic          commit_done;
    logic [2:0]    dec_in;
    logic [6:0]    dec_out;
    logic [6:0]    seg_out;
    logic [ND-1:0] an_out;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DIV         (DV),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .wr_on       (wr_on),
        .commit_valid(commit_valid),
        .commit_ready(commit_ready),
        .commit_done (commit_done),
        .dec_in      (dec_in),
        .dec_out     (dec_out),
        .seg_out     (seg_out),
        .an_out      (an_out)
    );

    // Active-low gfedcba patterns of the shared decoder.
    function automatic logic [6:0] segLut(input logic [2:0] v);
        case (v)
            3'd0:    segLut = 7'b1000000;
            3'd1:    segLut = 7'b1111001;
            3'd2:    segLut = 7'b0100100;
            3'd3:    segLut = 7'b0110000;
            3'd4:    segLut = 7'b0011001;
            3'd5:    segLut = 7'b0010010;
            3'd6:    segLut = 7'b0000010;
            default: segLut = 7'b1111000;
        endcase
    endfunction

    assign dec_out = segLut(dec_in);

    int compared   = 0;
    int mismatched = 0;

    int         t;
    int         shadowVal[ND];
    bit         shadowOn[ND];
    int         activeVal[ND];
    bit         activeOn[ND];
    bit         pending;
    bit         expDone;
    logic [6:0] expSeg;
    logic [3:0] expAn;
    bit         modelLive = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0d time %0t", tag, actual, expected, t, $time);
        end
    endtask

    // One clock cycle: check what the pins show now, drive inputs, advance the model.
    task automatic applyStimulus(input bit r, input bit wv, input int wi, input int wd,
                                 input bit won, input bit cv);
        int  cnt;
        int  slot;
        bit  wasPending;
        @(negedge clk);
        cnt  = t % DV;
        slot = (t / DV) % ND;
        if (modelLive) begin
            checkOutput("seg_out", 32'(seg_out), 32'(expSeg));
            checkOutput("an_out", 32'(an_out), 32'(expAn));
            checkOutput("commit_done", 32'(commit_done), 32'(expDone));
            checkOutput("wr_ready", 32'(wr_ready), 32'(!pending));
            checkOutput("commit_ready", 32'(commit_ready), 32'(!pending));
            checkOutput("dec_in", 32'(dec_in), 32'(activeVal[slot]));
        end
        rst          = r;
        wr_valid     = wv;
        wr_idx       = 3'(wi);
        wr_data      = 3'(wd);
        wr_on        = won;
        commit_valid = cv;
        if (r) begin
            modelLive = 1'b1;
            t         = 0;
            pending   = 1'b0;
            expDone   = 1'b0;
            expSeg    = 7'h7F;
            expAn     = 4'hF;
            for (int i = 0; i < ND; i++) begin
                shadowVal[i] = 0;
                shadowOn[i]  = 1'b0;
                activeVal[i] = 0;
                activeOn[i]  = 1'b0;
            end
        end else begin
            if (cnt < BC || !activeOn[slot]) begin
                expSeg = 7'h7F;
                expAn  = 4'hF;
            end else begin
                expSeg = segLut(3'(activeVal[slot]));
                expAn  = ~(4'd1 << slot);
            end
            expDone    = 1'b0;
            wasPending = pending;
            if (!wasPending && wv && wi < ND) begin
                shadowVal[wi] = wd;
                shadowOn[wi]  = won;
            end
            if (!wasPending && cv) pending = 1'b1;
            if (wasPending && (t % FRAME == FRAME - 1)) begin
                for (int i = 0; i < ND; i++) begin
                    activeVal[i] = shadowVal[i];
                    activeOn[i]  = shadowOn[i];
                end
                pending = 1'b0;
                expDone = 1'b1;
            end
            t++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        wr_valid     = 1'b0;
        wr_idx       = '0;
        wr_data      = '0;
        wr_on        = 1'b0;
        commit_valid = 1'b0;
        t            = 0;

        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(FRAME);

        // Load four lit digits and commit mid-frame.
        applyStimulus(1'b0, 1'b1, 0, 1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 3, 7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME);

        // Write held against a pending commit.
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        repeat (FRAME + 5) applyStimulus(1'b0, 1'b1, 0, 4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME);

        // Same-cycle write and commit.
        applyStimulus(1'b0, 1'b1, 2, 5, 1'b1, 1'b1);
        idle(2 * FRAME);

        // Dark digit plus an out-of-range write.
        applyStimulus(1'b0, 1'b1, 1, 6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME);

        // Commit accepted exactly on a frame-end cycle.
        while (t % FRAME != FRAME - 1) applyStimulus(1'b0, 1'b1, 1, 5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(2 * FRAME + 2);

        repeat (1500) begin
            applyStimulus($urandom_range(0, 599) == 0,
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0);
        end
        idle(FRAME);

        // Reset in the SHOW phase of a slot with a commit pending.
        applyStimulus(1'b0, 1'b1, 0, 6, 1'b1, 1'b1);
        while (t % DV != 5) idle(1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(2 * FRAME + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of 7-segment digits that share one 3-bit-to-7-segment decoder. It holds a double-buffered digit store: a shadow store written over a valid/ready port, and an active store that is only updated at frame boundaries on a commit. It sequences the shared decoder input, blanking guard intervals and active-low anode selects. It sits between the CPU-side display register interface and the board segment/anode pins.

Parameters:
NUM_DIGITS, 8, number of scanned digits; legal range 1..8.
DIV, 1000, clk cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off (anti-ghosting); 0 means no blank interval.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accept; equals !commit_pending
wr_idx  in  3  target digit index
wr_data  in  3  digit value, 0..7
wr_on  in  1  digit enable bit stored with the value (0 = digit dark)
commit_valid  in  1  request to copy shadow to active at the next frame end
commit_ready  out  1  equals !commit_pending
commit_done  out  1  one-cycle pulse on the cycle after the copy occurs
dec_in  out  3  to shared decoder; combinational, equals active value of the current slot digit
dec_out  in  7  from shared decoder; active-low segments, combinational from dec_in
seg_out  out  7  registered active-low segments to pins
an_out  out  NUM_DIGITS  registered active-low anode selects

Behaviour:
- Reset (sync, rst=1 at posedge): shadow and active values are 0, enables are 0; slot index is 0; prescaler is 0; commit_pending=0; commit_done=0; seg_out=7'h7F; an_out=all ones. Reset mid-frame or with a pending commit discards everything; no commit_done is produced.
- Prescaler cnt counts 0..DIV-1 and wraps. On the wrap, slot idx increments modulo NUM_DIGITS. Frame length is NUM_DIGITS*DIV cycles.
- Frame end is the cycle where cnt==DIV-1 and idx==NUM_DIGITS-1.
- Slot phases:
  - BLANK while cnt<BLANK_CYCLES.
  - SHOW otherwise.
- Output registers (1-cycle latency from the phase/idx of cycle t to the pins at t+1):
  - BLANK: seg_out<=7'h7F, an_out<=all ones.
  - SHOW with active_on[idx]=1: seg_out<=dec_out, an_out<=~(1<<idx).
  - SHOW with active_on[idx]=0: seg_out<=7'h7F, an_out<=all ones.
- Write: a handshake fires when wr_valid&&wr_ready. It writes shadow[wr_idx] = {wr_on, wr_data}. If wr_idx>=NUM_DIGITS, the write is accepted and ignored.
- Commit: a handshake fires when commit_valid&&commit_ready and sets commit_pending.
  - While pending, wr_ready=0 and commit_ready=0, so the shadow is frozen.
  - On the first frame-end cycle strictly after the accept cycle: active<=shadow, commit_pending<=0, commit_done<=1 for exactly the next cycle.
  - A commit accepted on a frame-end cycle is applied at the following frame end.
- Simultaneous write and commit handshake in the same cycle: the write lands in the shadow and is included in that commit.
- The copy takes effect for slot 0 of the new frame. The displayed digit never changes mid-frame.
- commit_done and a new commit accept may coincide: commit_ready is already 1 on the commit_done cycle.

Test Plan:
- Config NUM_DIGITS=4, DIV=10, BLANK_CYCLES=2. Release reset; observe the first 40 cycles -> an_out=4'hF and seg_out=7'h7F throughout (all enables 0). wr_ready=1 and commit_ready=1.
- Write idx0..3 = (on,1),(on,2),(on,3),(on,7). Commit at cycle 5 -> commit_done pulses exactly once, the cycle after the first frame end (cycle 39). In the next frame, slot 0 shows an_out=4'hF for 2 cycles, then 4'hE with seg_out=7'b1111001 for 8 cycles; slot 3 shows seg_out=7'b1111000 with an_out=4'h7.
- With a commit pending, hold wr_valid=1 -> wr_ready=0 and shadow unchanged until the commit_done cycle; the write is accepted on the commit_done cycle.
- Same-cycle write idx2=(on,5) plus commit -> after the next frame end, slot 2 outputs 7'b0010010 with an_out=4'hB.
- Write idx1=(off,6) and commit -> slot 1 stays an_out=4'hF, seg_out=7'h7F for the full slot. A write to wr_idx=6 leaves all digits unchanged.
- Assert rst for 1 cycle mid-SHOW with a commit pending -> next cycle an_out=4'hF, seg_out=7'h7F; no commit_done ever appears; the active store reads all 0/off.
